muxn_reg_hs: RTL and testbench
==============================

// Module: muxn_reg_hs
// PURPOSE
//   Registered N-channel data selector with valid/ready handshake on every channel.
//   Successor to the combinational 2-way reset-gated mux: generalised to NCH channels
//   and DW bits, with a one-entry output register and backpressure.
//   Sits between multiple datapath producers and a single consumer (e.g. ALU operand
//   or writeback path).
//   Channel choice: explicit select port, or an internal round-robin arbiter (see CONFIGURATION).
// PARAMETERS
//   DW   8  data width per channel, bits
//   NCH  4  number of input channels, 2..16
//   SW   2  select/channel-index width; must satisfy 2**SW >= NCH
// PORTS
//   clk        in   1       rising-edge clock
//   reset_n    in   1       reset, synchronous, active-low
//   in_data    in   NCH*DW  channel c occupies bits [c*DW +: DW]
//   in_valid   in   NCH     per-channel data valid
//   in_ready   out  NCH     per-channel accept; combinational
//   select     in   SW      channel to forward (select mode only)
//   out_data   out  DW      registered output data
//   out_valid  out  1       out_data holds an untaken word
//   out_ready  in   1       consumer accepts out_data this cycle
//   out_chan   out  SW      channel index that produced out_data
//   sel_err    out  1       registered; select >= NCH seen in the previous cycle
// BEHAVIOUR
//   Reset (reset_n==0 at clk edge), then registers clear:
//     out_data=0, out_valid=0, out_chan=0, sel_err=0, rr pointer=NCH-1.
//     in_ready is all 0 while reset_n==0 (combinational gate).
//   Definitions:
//     load_ok = !out_valid || out_ready
//     ch      = chosen channel this cycle
//     xfer    = load_ok && ch_ok && in_valid[ch]
//       ch_ok = select mode: select < NCH; rr mode: any in_valid bit set
//   Handshake:
//     in_ready[c] = reset_n && load_ok && ch_ok && (c==ch); at most one bit high.
//     A channel transfer occurs when in_valid[c] && in_ready[c].
//   Output register, on each clk edge when not in reset:
//     xfer                   -> out_data<=in_data[ch], out_chan<=ch, out_valid<=1
//     !xfer && out_ready     -> out_valid<=0; out_data and out_chan hold
//     out_valid && !out_ready -> all hold; out_data is stable under backpressure
//   Timing:
//     Latency 1 cycle input-to-output.
//     Throughput 1 word/cycle while out_ready is held high.
//     Simultaneous out_ready and xfer: the old word leaves and the new word loads
//     in the same edge; there is no bubble.
//   Out-of-range select (select >= NCH):
//     No transfer; all in_ready are 0.
//     sel_err<=1 on the next edge; sel_err<=0 on any edge with a legal select.
//   select is sampled every cycle, not latched. Changing select while the output
//   is stalled only affects which channel loads next.
//   Reset mid-transfer: the pending out word is discarded; no in_ready is asserted
//   during reset.
// CONFIGURATION
//   MUXN_RR_EN defined:
//     select is ignored; sel_err is tied 0.
//     ch is the first c with in_valid[c] set, searching ptr+1, ptr+2, ... modulo NCH.
//     On xfer, ptr<=ch; otherwise ptr holds.
//     Fairness: with all channels valid, grants rotate 0,1,..,NCH-1,0.
//   MUXN_RR_EN undefined:
//     Pure select mode; no ptr register is built.
// TESTING
//   Reset: hold reset_n=0 for 2 clk with all in_valid=1
//     -> out_valid=0, out_data=0, in_ready=0.
//   Select mode: DW=8, NCH=4, select=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1
//     -> in_ready=4'b0100; next cycle out_data=A5, out_chan=2, out_valid=1.
//   Backpressure: out_valid=1, out_ready=0 for 3 cycles while ch2 changes to 8'h3C
//     -> out_data stays A5, in_ready=0.
//     Then out_ready=1 -> 3C loads on the same edge A5 drains.
//   Bad select: NCH=3, select=3
//     -> in_ready=0, no load, sel_err=1 next cycle.
//     select=1 -> sel_err=0 next cycle.
//   Streaming: out_ready=1, ch1 valid for 8 cycles with data 1..8
//     -> out_data sequence 1..8 on consecutive cycles with no gaps.
//   RR (MUXN_RR_EN): all in_valid=1, out_ready=1
//     -> out_chan 0,1,2,3,0.
//     With in_valid=4'b1010 -> out_chan alternates 1,3.

Source files
------------

// File: rtl/muxn_reg_hs.sv
// Registered NCH-way data selector with valid/ready handshake per channel and a
// one-entry output register. Define MUXN_RR_EN for round-robin channel choice.
module muxn_reg_hs #(
    parameter int DW  = 8,
    parameter int NCH = 4,
    parameter int SW  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH*DW-1:0] in_data_i,
    input  logic [NCH-1:0]    in_valid_i,
    output logic [NCH-1:0]    in_ready_o,
    input  logic [SW-1:0]     select_i,
    output logic [DW-1:0]     out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [SW-1:0]     out_chan_o,
    output logic              sel_err_o
);

    logic [SW-1:0] ch;
    logic          ch_ok;
    logic          ch_vld;
    logic [DW-1:0] ch_data;
    logic          load_ok;
    logic          xfer;

    logic [DW-1:0] out_data_q, out_data_d;
    logic [SW-1:0] out_chan_q, out_chan_d;
    logic          out_valid_q, out_valid_d;

`ifdef MUXN_RR_EN
    logic [SW-1:0] ptr_q, ptr_d;

    // Scan from farthest to nearest so the first valid after ptr wins.
    always_comb begin
        int idx;
        idx   = 0;
        ch    = ptr_q;
        ch_ok = 1'b0;
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % NCH;
            if (in_valid_i[idx]) begin
                ch    = SW'(idx);
                ch_ok = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = ch;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) ptr_q <= SW'(NCH - 1);
        else          ptr_q <= ptr_d;
    end

    assign sel_err_o = 1'b0;
`else
    logic sel_err_q;

    assign ch    = select_i;
    assign ch_ok = (int'(select_i) < NCH);

    always_ff @(posedge clk) begin
        if (!reset_n) sel_err_q <= 1'b0;
        else          sel_err_q <= !ch_ok;
    end

    assign sel_err_o = sel_err_q;
`endif

    // Mux by comparison so an out-of-range select never indexes past the bus.
    always_comb begin
        ch_data = '0;
        ch_vld  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_ok && (int'(ch) == c)) begin
                ch_data = in_data_i[c*DW +: DW];
                ch_vld  = in_valid_i[c];
            end
        end
    end

    assign load_ok = !out_valid_q || out_ready_i;
    assign xfer    = load_ok && ch_vld;

    for (genvar c = 0; c < NCH; c++) begin : g_rdy
        assign in_ready_o[c] = reset_n && load_ok && ch_ok && (ch == SW'(c));
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = ch_data;
            out_chan_d  = ch;
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_chan_o  = out_chan_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_muxn_reg_hs.sv
// Bench for muxn_reg_hs: a 4-channel and a 3-channel instance share one random
// stimulus stream and are compared against a transaction-level model.
module tb_muxn_reg_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0] rdy4;
    logic [7:0] od4;
    logic       ov4;
    logic [1:0] oc4;
    logic       se4;

    logic [2:0] rdy3;
    logic [7:0] od3;
    logic       ov3;
    logic [1:0] oc3;
    logic       se3;

    muxn_reg_hs #(.DW(8), .NCH(4), .SW(2)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(rdy4),
        .select_i(sel), .out_data_o(od4), .out_valid_o(ov4),
        .out_ready_i(out_ready), .out_chan_o(oc4), .sel_err_o(se4)
    );

    muxn_reg_hs #(.DW(8), .NCH(3), .SW(2)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .in_data_i(in_data[23:0]), .in_valid_i(in_valid[2:0]), .in_ready_o(rdy3),
        .select_i(sel), .out_data_o(od3), .out_valid_o(ov3),
        .out_ready_i(out_ready), .out_chan_o(oc3), .sel_err_o(se3)
    );

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = 4-channel instance, 1 = 3-channel instance.
    int m_valid[2];
    int m_data[2];
    int m_chan[2];
    int m_err[2];
    int m_ptr[2];

    function automatic int nch_of(input int m);
        return (m == 0) ? 4 : 3;
    endfunction

    function automatic int pick(input int m);
        int n;
        n = nch_of(m);
`ifdef MUXN_RR_EN
        for (int k = 1; k <= n; k++) begin
            if (in_valid[(m_ptr[m] + k) % n]) return (m_ptr[m] + k) % n;
        end
        return -1;
`else
        return (int'(sel) < n) ? int'(sel) : -1;
`endif
    endfunction

    function automatic int exp_ready(input int m);
        int p;
        p = pick(m);
        if (reset_n !== 1'b1) return 0;
        if ((m_valid[m] == 0 || out_ready) && p >= 0) return 1 << p;
        return 0;
    endfunction

    task automatic model_edge(input int m);
        int p, n;
        bit lo;
        n  = nch_of(m);
        p  = pick(m);
        lo = (m_valid[m] == 0) || out_ready;
        if (!reset_n) begin
            m_valid[m] = 0; m_data[m] = 0; m_chan[m] = 0; m_err[m] = 0;
            m_ptr[m] = n - 1;
        end else begin
            if (lo && p >= 0 && in_valid[p]) begin
                m_valid[m] = 1;
                m_data[m]  = int'(in_data[p*8 +: 8]);
                m_chan[m]  = p;
                m_ptr[m]   = p;
            end else if (out_ready) begin
                m_valid[m] = 0;
            end
`ifdef MUXN_RR_EN
            m_err[m] = 0;
`else
            m_err[m] = (int'(sel) >= n) ? 1 : 0;
`endif
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check readies against the model, advance, check registers.
    task automatic cyc();
        #1;
        chk("ready4", int'(rdy4), exp_ready(0));
        chk("ready3", int'(rdy3), exp_ready(1));
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        chk("valid4", int'(ov4), m_valid[0]);
        chk("data4",  int'(od4), m_data[0]);
        chk("chan4",  int'(oc4), m_chan[0]);
        chk("err4",   int'(se4), m_err[0]);
        chk("valid3", int'(ov3), m_valid[1]);
        chk("data3",  int'(od3), m_data[1]);
        chk("chan3",  int'(oc3), m_chan[1]);
        chk("err3",   int'(se3), m_err[1]);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_data[m] = 0; m_chan[m] = 0; m_err[m] = 0;
            m_ptr[m] = nch_of(m) - 1;
        end
        reset_n   = 1'b0;
        in_data   = 32'h0;
        in_valid  = 4'hF;
        sel       = 2'd0;
        out_ready = 1'b0;
        #2;

        cyc();
        cyc();
        chk("rst_valid", int'(ov4), 0);
        chk("rst_data",  int'(od4), 0);
        chk("rst_ready", int'(rdy4), 0);
        reset_n  = 1'b1;
        in_valid = 4'h0;
        cyc();

`ifndef MUXN_RR_EN
        sel       = 2'd2;
        in_data   = 32'h00A5_0000;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        chk("sel_ready", int'(rdy4), 4);
        cyc();
        chk("sel_data",  int'(od4), 8'hA5);
        chk("sel_chan",  int'(oc4), 2);
        chk("sel_valid", int'(ov4), 1);

        out_ready = 1'b0;
        in_data   = 32'h003C_0000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_data",  int'(od4), 8'hA5);
            chk("bp_ready", int'(rdy4), 0);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_reload", int'(od4), 8'h3C);
        chk("bp_valid",  int'(ov4), 1);

        sel      = 2'd3;
        in_valid = 4'hF;
        cyc();
        chk("bad_err",   int'(se3), 1);
        chk("bad_ready", int'(rdy3), 0);
        sel = 2'd1;
        cyc();
        chk("bad_clear", int'(se3), 0);

        in_valid = 4'b0010;
        for (int i = 1; i <= 8; i++) begin
            in_data = {16'h0, 8'(i), 8'h0};
            cyc();
            chk("stream_data",  int'(od4), i);
            chk("stream_valid", int'(ov4), 1);
        end
`else
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            cyc();
            chk("rr_all", int'(oc4), i % 4);
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_alt", int'(oc4), (i % 2 == 0) ? 1 : 3);
        end
`endif

        for (int i = 0; i < 400; i++) begin
            reset_n   = ($urandom % 40) != 0;
            in_data   = $urandom;
            in_valid  = 4'($urandom);
            sel       = 2'($urandom_range(0, 3));
            out_ready = ($urandom % 4) != 0;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
